// File: rtl/video_tpg_multi.sv
// rtl/video_tpg_multi.sv - multi-channel video timing raster and test-pattern source
module video_tpg_multi #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int CH_NUM   = 2,
    parameter int COMP_W   = 8,
    parameter bit SYNC_POL = 1'b1,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL),
    localparam int PW      = 3 * COMP_W,
    localparam int DW      = CH_NUM * PW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [1:0]    mode,
    output logic          vsync,
    output logic          hsync,
    output logic          de,
    output logic [DW-1:0] data,
    output logic [HW-1:0] x_pos,
    output logic [VW-1:0] y_pos,
    output logic [15:0]   frame_cnt,
    output logic          sof
);

    localparam int BW = H_ACTIVE / 8;

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [1:0]    mode_q, mode_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          vsync_q, vsync_d;
    logic          hsync_q, hsync_d;
    logic          de_q, de_d;
    logic          sof_q, sof_d;
    logic [DW-1:0] data_q, data_d;
    logic [HW-1:0] x_pos_q, x_pos_d;
    logic [VW-1:0] y_pos_q, y_pos_d;

    logic [31:0]       h32, v32, c32;
    logic              h_last, v_last, first_px, active;
    logic [1:0]        pix_mode;
    logic [DW-1:0]     pix;
    logic [2:0]        bar;
    logic              chk;
    logic [COMP_W-1:0] ramp_c, fid_c;

    assign h32      = 32'(h_cnt_q);
    assign v32      = 32'(v_cnt_q);
    assign h_last   = (h32 == 32'(H_TOTAL - 1));
    assign v_last   = (v32 == 32'(V_TOTAL - 1));
    assign first_px = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign active   = (h32 < 32'(H_ACTIVE)) && (v32 < 32'(V_ACTIVE));
    // The pixel that opens a frame already uses the mode being latched on its edge.
    assign pix_mode = first_px ? mode : mode_q;

    // Raster advance and timing outputs; en low parks the raster at (0,0) with idle outputs.
    always_comb begin
        h_cnt_d     = '0;
        v_cnt_d     = '0;
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        vsync_d     = ~SYNC_POL;
        hsync_d     = ~SYNC_POL;
        de_d        = 1'b0;
        sof_d       = 1'b0;
        data_d      = '0;
        x_pos_d     = '0;
        y_pos_d     = '0;
        if (en) begin
            h_cnt_d = h_last ? '0 : h_cnt_q + HW'(1);
            if (h_last) begin
                v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
            end else begin
                v_cnt_d = v_cnt_q;
            end
            if (h_last && v_last) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
            if (first_px) begin
                mode_d = mode;
            end
            hsync_d = ((h32 >= 32'(H_ACTIVE + H_FP)) && (h32 < 32'(H_ACTIVE + H_FP + H_SYNC)))
                      ? SYNC_POL : ~SYNC_POL;
            vsync_d = ((v32 >= 32'(V_ACTIVE + V_FP)) && (v32 < 32'(V_ACTIVE + V_FP + V_SYNC)))
                      ? SYNC_POL : ~SYNC_POL;
            de_d    = active;
            sof_d   = first_px;
            data_d  = active ? pix : '0;
            x_pos_d = h_cnt_q;
            y_pos_d = v_cnt_q;
        end
    end

    // Per-channel pattern generation; the channel index shifts each pattern.
    always_comb begin
        pix    = '0;
        c32    = '0;
        bar    = '0;
        chk    = 1'b0;
        ramp_c = '0;
        fid_c  = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            c32    = 32'(c);
            bar    = 3'(h32 / 32'(BW) + c32);
            chk    = h32[5] ^ v32[5] ^ c32[0];
            ramp_c = COMP_W'(h32 + 32'd32 * c32);
            fid_c  = COMP_W'(32'(frame_cnt_q) + c32);
            case (pix_mode)
                // Bar order white..black maps to RGB = ~{idx[1], idx[2], idx[0]}.
                2'd0:    pix[c*PW +: PW] = {{COMP_W{~bar[1]}}, {COMP_W{~bar[2]}}, {COMP_W{~bar[0]}}};
                2'd1:    pix[c*PW +: PW] = {3{ramp_c}};
                2'd2:    pix[c*PW +: PW] = {PW{~chk}};
                default: pix[c*PW +: PW] = {3{fid_c}};
            endcase
        end
    end

    // State and registered outputs, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            mode_q      <= '0;
            frame_cnt_q <= '0;
            vsync_q     <= ~SYNC_POL;
            hsync_q     <= ~SYNC_POL;
            de_q        <= 1'b0;
            sof_q       <= 1'b0;
            data_q      <= '0;
            x_pos_q     <= '0;
            y_pos_q     <= '0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            vsync_q     <= vsync_d;
            hsync_q     <= hsync_d;
            de_q        <= de_d;
            sof_q       <= sof_d;
            data_q      <= data_d;
            x_pos_q     <= x_pos_d;
            y_pos_q     <= y_pos_d;
        end
    end

    assign vsync     = vsync_q;
    assign hsync     = hsync_q;
    assign de        = de_q;
    assign sof       = sof_q;
    assign data      = data_q;
    assign x_pos     = x_pos_q;
    assign y_pos     = y_pos_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_video_tpg_multi.sv
// tb/tb_video_tpg_multi.sv - randomized model-checked bench for video_tpg_multi
module tb_video_tpg_multi;

    localparam int HA = 16, HFP = 2, HS = 2, HBP = 2;
    localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
    localparam int CH = 2, CW = 8;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FR = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        vsync, hsync, de, sof;
    logic [47:0] data;
    logic [4:0]  x_pos;
    logic [2:0]  y_pos;
    logic [15:0] frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: enabled edges since restart, completed frames, latched mode
    int m_t = 0;
    int m_fc = 0;
    int m_mode = 0;
    logic [23:0] bar_tab [8];

    video_tpg_multi #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .CH_NUM(CH), .COMP_W(CW), .SYNC_POL(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .vsync(vsync), .hsync(hsync), .de(de), .data(data),
        .x_pos(x_pos), .y_pos(y_pos), .frame_cnt(frame_cnt), .sof(sof)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] exp_pix(int h, int v, int c, int md, int fc);
        int k;
        case (md)
            0: return bar_tab[((h / (HA / 8)) + c) % 8];
            1: begin k = (h + 32 * c) % 256; return {k[7:0], k[7:0], k[7:0]}; end
            2: return ((((h / 32) + (v / 32) + c) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
            default: begin k = (fc + c) % 256; return {k[7:0], k[7:0], k[7:0]}; end
        endcase
    endfunction

    // One clock: advance the model by one edge and compare every output.
    task automatic step();
        int p, h, v;
        logic e_vs, e_hs, e_de, e_sof;
        logic [47:0] e_data;
        int ex, ey;
        @(posedge clk);
        #1;
        e_vs = 1'b0; e_hs = 1'b0; e_de = 1'b0; e_sof = 1'b0; e_data = '0; ex = 0; ey = 0;
        if (!rst_n) begin
            m_t = 0; m_fc = 0; m_mode = 0;
        end else if (!en) begin
            m_t = 0;
        end else begin
            p = m_t % FR;
            h = p % HT;
            v = p / HT;
            if (p == 0) m_mode = int'(mode);
            e_de = (h < HA) && (v < VA);
            if (e_de) begin
                for (int c = 0; c < CH; c++) e_data[c*24 +: 24] = exp_pix(h, v, c, m_mode, m_fc);
            end
            e_hs  = (h >= HA + HFP) && (h < HA + HFP + HS);
            e_vs  = (v >= VA + VFP) && (v < VA + VFP + VS);
            e_sof = (p == 0);
            ex = h; ey = v;
            if (p == FR - 1) m_fc = (m_fc + 1) % 65536;
            m_t++;
        end
        check("vsync", vsync, e_vs);
        check("hsync", hsync, e_hs);
        check("de", de, e_de);
        check("sof", sof, e_sof);
        check("data", data, e_data);
        check("x_pos", x_pos, ex);
        check("y_pos", y_pos, ey);
        check("frame_cnt", frame_cnt, m_fc);
    endtask

    task automatic run_to_sof();
        for (int k = 0; k < 2 * FR; k++) begin
            step();
            if (sof) return;
        end
        check("sof_timeout", 0, 1);
    endtask

    initial begin
        int de_n, vs_n, hs_n, bad_hs, bad_vs, sof_n, cyc, last_sof, fc_hold;
        bar_tab[0] = 24'hFFFFFF; bar_tab[1] = 24'hFFFF00; bar_tab[2] = 24'h00FFFF; bar_tab[3] = 24'h00FF00;
        bar_tab[4] = 24'hFF00FF; bar_tab[5] = 24'hFF0000; bar_tab[6] = 24'h0000FF; bar_tab[7] = 24'h000000;

        // reset held, then released with en low
        repeat (5) step();
        rst_n = 1'b1;
        repeat (5) step();

        // raster: three frames of colour bars
        en = 1'b1; mode = 2'd0;
        de_n = 0; vs_n = 0; hs_n = 0; bad_hs = 0; bad_vs = 0; sof_n = 0; last_sof = -1;
        for (cyc = 0; cyc < 3 * FR; cyc++) begin
            step();
            if (de) de_n++;
            if (vsync) begin vs_n++; if (y_pos != 3'd5) bad_vs++; end
            if (hsync) begin hs_n++; if (x_pos != 5'd18 && x_pos != 5'd19) bad_hs++; end
            if (sof) begin
                sof_n++;
                if (last_sof >= 0) check("sof_period", cyc - last_sof, FR);
                last_sof = cyc;
                if (sof_n == 3) check("fc_frame3", frame_cnt, 2);
            end
            if (sof_n == 1 && y_pos == 3'd0 && de) begin
                if (x_pos <= 5'd1) begin
                    check("bar_ch0_x01", data[23:0], 24'hFFFFFF);
                    check("bar_ch1_x01", data[47:24], 24'hFFFF00);
                end else if (x_pos <= 5'd3) begin
                    check("bar_ch0_x23", data[23:0], 24'hFFFF00);
                end else if (x_pos >= 5'd14) begin
                    check("bar_ch0_x1415", data[23:0], 24'h000000);
                    check("bar_ch1_x1415", data[47:24], 24'hFFFFFF);
                end
            end
        end
        check("de_count", de_n, 3 * 64);
        check("vs_count", vs_n, 3 * 22);
        check("hs_count", hs_n, 3 * VT * 2);
        check("hs_position", bad_hs, 0);
        check("vs_line", bad_vs, 0);

        // ramp
        mode = 2'd1;
        run_to_sof();
        for (int k = 0; k < FR - 1; k++) begin
            step();
            if (y_pos == 3'd0 && x_pos == 5'd5) check("ramp_ch1_x5", data[47:24], 24'h252525);
        end

        // checker
        mode = 2'd2;
        run_to_sof();
        check("chk_ch0_00", data[23:0], 24'hFFFFFF);
        check("chk_ch1_00", data[47:24], 24'h000000);

        // mode latch: ramp frame with a mid-frame switch to frame-id
        mode = 2'd1;
        run_to_sof();
        repeat (40) step();
        mode = 2'd3;
        run_to_sof();
        check("fid_ch0", data[23:0], {3{m_fc[7:0]}});
        fc_hold = m_fc + 1;
        check("fid_ch1", data[47:24], {3{fc_hold[7:0]}});

        // enable abort at (7,2)
        for (int k = 0; k < 2 * FR; k++) begin
            step();
            if (y_pos == 3'd2 && x_pos == 5'd7) break;
        end
        check("abort_reach", {y_pos, x_pos}, {3'd2, 5'd7});
        en = 1'b0;
        fc_hold = m_fc;
        repeat (3) begin
            step();
            check("abort_de", de, 1'b0);
            check("abort_fc_hold", frame_cnt, fc_hold);
        end
        en = 1'b1;
        step();
        check("restart_sof", sof, 1'b1);
        check("restart_xy", {y_pos, x_pos}, 8'd0);

        // randomized run: random mode changes and occasional enable drops
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            en = ($urandom_range(0, 299) != 0);
            step();
        end

        // asynchronous reset mid-frame
        en = 1'b1;
        repeat (30) step();
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_de", de, 1'b0);
        check("arst_hsync", hsync, 1'b0);
        check("arst_vsync", vsync, 1'b0);
        check("arst_data", data, 48'd0);
        check("arst_xy", {y_pos, x_pos}, 8'd0);
        check("arst_fc", frame_cnt, 16'd0);
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("arst_restart_sof", sof, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
